// File: rtl/ita_package.sv
// Shared ITA parameters and the divider-scheduler slot/tag/count types.
package ita_package;

  localparam int unsigned NumDiv          = 4;
  localparam int unsigned DividerWidth    = 24;
  localparam int unsigned InputAddrWidth  = 5;

  localparam int unsigned DivSlotIdxWidth = (NumDiv > 1) ? $clog2(NumDiv) : 1;
  localparam int unsigned DivCntWidth     = $clog2(NumDiv + 1);

  typedef logic [InputAddrWidth-1:0]  div_tag_t;
  typedef logic [DivSlotIdxWidth-1:0] div_slot_idx_t;
  typedef logic [DivCntWidth-1:0]     div_cnt_t;

endpackage

// File: rtl/ita_div_scheduler.sv
// Round-robin dispatch of softmax division requests onto NumDiv serial dividers,
// with in-order tagged responses. Optional feature macro: ITA_DIV_SCHED_ZERO_GUARD_EN.
module ita_div_scheduler #(
  parameter int unsigned NumDiv       = ita_package::NumDiv,
  parameter int unsigned DividerWidth = ita_package::DividerWidth,
  parameter int unsigned TagWidth     = ita_package::InputAddrWidth,
  localparam int unsigned IdxWidth    = (NumDiv > 1) ? $clog2(NumDiv) : 1,
  localparam int unsigned CntWidth    = $clog2(NumDiv + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [DividerWidth-1:0]              req_divisor_i,
  input  logic [TagWidth-1:0]                  req_tag_i,
  output logic [NumDiv-1:0]                    div_valid_o,
  input  logic [NumDiv-1:0]                    div_ready_i,
  output logic [DividerWidth-1:0]              div_op_b_o,
  output logic                                 div_flush_o,
  input  logic [NumDiv-1:0]                    div_valid_i,
  output logic [NumDiv-1:0]                    div_ready_o,
  input  logic [NumDiv-1:0][DividerWidth-1:0]  div_res_i,
  output logic                                 rsp_valid_o,
  input  logic                                 rsp_ready_i,
  output logic [DividerWidth-1:0]              rsp_res_o,
  output logic [TagWidth-1:0]                  rsp_tag_o,
  output logic [CntWidth-1:0]                  outstanding_o,
  output logic                                 idle_o
);

  logic [NumDiv-1:0]   occ_q, occ_d;
  logic [TagWidth-1:0] tag_q [NumDiv];
  logic [IdxWidth-1:0] disp_q, disp_d, ret_q, ret_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                active, accept, retire;
`ifdef ITA_DIV_SCHED_ZERO_GUARD_EN
  logic [NumDiv-1:0]   zero_q;
  logic                zero_req;
`endif

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
    return (idx == IdxWidth'(NumDiv - 1)) ? '0 : idx + IdxWidth'(1);
  endfunction

  // Dispatch, retire and slot bookkeeping; all handshakes are pass-through.
  always_comb begin
    occ_d       = occ_q;
    disp_d      = disp_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    div_valid_o = '0;
    div_ready_o = '0;
    active      = !rst_i && !flush_i;
    div_flush_o = flush_i;
    div_op_b_o  = req_divisor_i;
`ifdef ITA_DIV_SCHED_ZERO_GUARD_EN
    zero_req    = (req_divisor_i == '0);
    if (zero_req) div_op_b_o = DividerWidth'(1);
`endif

    req_ready_o         = active && !occ_q[disp_q] && div_ready_i[disp_q];
    div_valid_o[disp_q] = active && req_valid_i && !occ_q[disp_q];

    rsp_valid_o         = active && occ_q[ret_q] && div_valid_i[ret_q];
    div_ready_o[ret_q]  = active && occ_q[ret_q] && rsp_ready_i;
    rsp_res_o           = div_res_i[ret_q];
`ifdef ITA_DIV_SCHED_ZERO_GUARD_EN
    if (zero_q[ret_q]) rsp_res_o = '1;
`endif
    rsp_tag_o           = tag_q[ret_q];

    accept = req_valid_i && req_ready_o;
    retire = rsp_valid_o && rsp_ready_i;

    if (accept) begin
      occ_d[disp_q] = 1'b1;
      disp_d        = next_idx(disp_q);
    end
    if (retire) begin
      occ_d[ret_q] = 1'b0;
      ret_d        = next_idx(ret_q);
    end

    unique case ({accept, retire})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase

    outstanding_o = cnt_q;
    idle_o        = (cnt_q == '0);
  end

  // Flush shares the reset path for occupancy, pointers and count.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occ_q  <= '0;
      disp_q <= '0;
      ret_q  <= '0;
      cnt_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      disp_q <= disp_d;
      ret_q  <= ret_d;
      cnt_q  <= cnt_d;
    end
  end

  // Per-slot payload captured on accept; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumDiv; i++) tag_q[i] <= '0;
`ifdef ITA_DIV_SCHED_ZERO_GUARD_EN
      zero_q <= '0;
`endif
    end else if (accept) begin
      tag_q[disp_q] <= req_tag_i;
`ifdef ITA_DIV_SCHED_ZERO_GUARD_EN
      zero_q[disp_q] <= zero_req;
`endif
    end
  end

endmodule

// File: tb/tb_ita_div_scheduler.sv
// Scoreboard bench for ita_div_scheduler with a behavioural 65536/b divider array.
module tb_ita_div_scheduler;

  localparam int ND = 4;
  localparam int DW = 24;
  localparam int TW = 5;
  localparam int CW = $clog2(ND + 1);

  logic                  clk = 1'b0;
  logic                  rst, flush, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [DW-1:0]         req_divisor, div_op_b, rsp_res;
  logic [TW-1:0]         req_tag, rsp_tag;
  logic [ND-1:0]         div_valid, div_ready_in, div_valid_in, div_ready_out;
  logic [ND-1:0][DW-1:0] div_res;
  logic                  div_flush, idle;
  logic [CW-1:0]         outstanding;

  ita_div_scheduler #(.NumDiv(ND), .DividerWidth(DW), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_divisor_i(req_divisor), .req_tag_i(req_tag),
    .div_valid_o(div_valid), .div_ready_i(div_ready_in),
    .div_op_b_o(div_op_b), .div_flush_o(div_flush),
    .div_valid_i(div_valid_in), .div_ready_o(div_ready_out),
    .div_res_i(div_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_res_o(rsp_res), .rsp_tag_o(rsp_tag),
    .outstanding_o(outstanding), .idle_o(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider array model: fixed per-divider latency, holds result until taken.
  logic [ND-1:0] m_busy = '0, m_done = '0;
  int            m_t [ND];
  logic [DW-1:0] m_res [ND];
  int            lat [ND];

  assign div_ready_in = ~m_busy;
  assign div_valid_in = m_done;
  always_comb for (int i = 0; i < ND; i++) div_res[i] = m_res[i];

  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (rst || div_flush) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_t[i] <= 0;
      end else if (!m_busy[i]) begin
        if (div_valid[i]) begin
          m_busy[i] <= 1'b1;
          m_t[i]    <= lat[i];
          m_res[i]  <= (div_op_b == '0) ? 24'hDEAD00 : DW'(65536 / div_op_b);
        end
      end else if (m_t[i] > 1) begin
        m_t[i] <= m_t[i] - 1;
      end else if (m_t[i] == 1) begin
        m_t[i] <= 0; m_done[i] <= 1'b1;
      end else if (m_done[i] && div_ready_out[i]) begin
        m_done[i] <= 1'b0; m_busy[i] <= 1'b0;
      end
    end
  end

  int checks = 0, errors = 0;
  logic [DW+TW-1:0] q[$];
  int exp_slot = 0, acc_cyc = 0, last_rsp_cyc = 0;
  logic [DW-1:0] last_opb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rsp_valid && flush) chk("rsp_valid_during_flush", 32'(rsp_valid), 32'd0);
    if (rsp_valid && rsp_ready) begin
      last_rsp_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_response", 32'(rsp_tag), 32'hFFFFFFFF);
      end else begin
        logic [DW+TW-1:0] e;
        e = q.pop_front();
        chk("rsp_res", 32'(rsp_res), 32'(e[DW+TW-1:TW]));
        chk("rsp_tag", 32'(rsp_tag), 32'(e[TW-1:0]));
      end
    end
  end

  task automatic send(input logic [DW-1:0] b, input logic [TW-1:0] tag,
                      input logic [DW-1:0] exp_res, output int stalls);
    bit done = 0;
    stalls = 0;
    req_valid = 1'b1; req_divisor = b; req_tag = tag;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        chk("dispatch_slot", 32'(div_valid), 32'(1 << exp_slot));
        last_opb = div_op_b;
        q.push_back({exp_res, tag});
        acc_cyc  = cyc + 1;
        exp_slot = (exp_slot + 1) % ND;
        done = 1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          chk("send_timeout", 32'(stalls), 32'd0);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(idle && q.size() == 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) chk("wait_idle_timeout", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    chk("flush_div_flush", 32'(div_flush), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    q.delete();
    exp_slot = 0;
    chk("post_flush_outstanding", 32'(outstanding), 32'd0);
    chk("post_flush_idle", 32'(idle), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_slot = 0;
    chk("post_rst_outstanding", 32'(outstanding), 32'd0);
    chk("post_rst_idle", 32'(idle), 32'd1);
  endtask

  initial begin
    int st;
    int held;
    logic [DW-1:0] r0;
    logic [TW-1:0] t0;
    for (int i = 0; i < ND; i++) lat[i] = 5;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    req_divisor = 24'd4; req_tag = 5'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_div_valid", 32'(div_valid), 32'd0);
    chk("reset_div_ready", 32'(div_ready_out), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_div_flush", 32'(div_flush), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;

    // Single request: 65536/4, five-cycle latency.
    chk("single_outstanding_pre", 32'(outstanding), 32'd0);
    send(24'd4, 5'd7, 24'd16384, st);
    chk("single_outstanding_mid", 32'(outstanding), 32'd1);
    wait_idle();
    chk("single_latency", 32'(last_rsp_cyc - acc_cyc), 32'd5);
    chk("single_outstanding_post", 32'(outstanding), 32'd0);
    do_flush();

    // Fill and stall: fifth request waits for slot 0 to retire.
    send(24'd1, 5'd1, 24'd65536, st); chk("fill_stall0", 32'(st), 32'd0);
    send(24'd2, 5'd2, 24'd32768, st); chk("fill_stall1", 32'(st), 32'd0);
    send(24'd4, 5'd3, 24'd16384, st); chk("fill_stall2", 32'(st), 32'd0);
    send(24'd8, 5'd4, 24'd8192, st);  chk("fill_stall3", 32'(st), 32'd0);
    chk("fill_outstanding_full", 32'(outstanding), 32'd4);
    send(24'd16, 5'd5, 24'd4096, st);
    chk("fill_stall4", 32'(st), 32'd3);
    wait_idle();
    do_flush();

    // Ordering: divider 1 finishes three cycles before divider 0.
    lat[0] = 8; lat[1] = 4;
    send(24'd4, 5'd3, 24'd16384, st);
    send(24'd8, 5'd9, 24'd8192, st);
    held = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_done[1] && m_busy[0]) begin
        held++;
        chk("order_slot1_held", 32'(div_ready_out[1]), 32'd0);
      end
    end
    chk("order_held_cycles", 32'(held), 32'd4);
    @(posedge clk); #1;
    wait_idle();
    lat[0] = 5; lat[1] = 5;
    do_flush();

    // Backpressure: results held stable for ten cycles, then drain in order.
    rsp_ready = 1'b0;
    send(24'd1, 5'd1, 24'd65536, st);
    send(24'd3, 5'd2, 24'd21845, st);
    send(24'd5, 5'd3, 24'd13107, st);
    send(24'd16, 5'd4, 24'd4096, st);
    st = 0;
    @(negedge clk);
    while (!rsp_valid && st < 50) begin @(negedge clk); st++; end
    chk("bp_first_valid", 32'(rsp_valid), 32'd1);
    r0 = rsp_res; t0 = rsp_tag;
    chk("bp_first_res", 32'(r0), 32'd65536);
    chk("bp_first_tag", 32'(t0), 32'd1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("bp_res_stable", 32'(rsp_res), 32'(r0));
      chk("bp_tag_stable", 32'(rsp_tag), 32'(t0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();
    do_flush();

    // Flush with three requests outstanding, then a fresh request.
    send(24'd4, 5'd10, 24'd16384, st);
    send(24'd4, 5'd11, 24'd16384, st);
    send(24'd4, 5'd12, 24'd16384, st);
    chk("flush_mid_outstanding", 32'(outstanding), 32'd3);
    do_flush();
    repeat (10) @(posedge clk); #1;
    send(24'd2, 5'd1, 24'd32768, st);
    wait_idle();
    do_flush();

    // Reset with three requests outstanding, then a fresh request.
    send(24'd4, 5'd10, 24'd16384, st);
    send(24'd4, 5'd11, 24'd16384, st);
    send(24'd4, 5'd12, 24'd16384, st);
    do_reset();
    repeat (10) @(posedge clk); #1;
    send(24'd2, 5'd1, 24'd32768, st);
    wait_idle();

    // Zero divisor.
`ifdef ITA_DIV_SCHED_ZERO_GUARD_EN
    send(24'd0, 5'd5, 24'hFFFFFF, st);
    chk("zero_op_b", 32'(last_opb), 32'd1);
`else
    send(24'd0, 5'd5, 24'hDEAD00, st);
    chk("zero_op_b", 32'(last_opb), 32'd0);
`endif
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ita_div_scheduler.md
# ita_div_scheduler

Shares the `NumDiv` serial dividers (`ita_serdiv`) among the division requests that `ita_softmax` issues during normalisation. Requests are dispatched round-robin, and each request carries a tag (the accumulator/row address). Results are returned strictly in request order, together with their tags. The block sits between `ita_softmax` and the divider array inside the softmax top. It replaces the direct per-divider valid/ready wiring with a single request stream and a single response stream.

## Interface
Parameters:
- `NumDiv`, default `ita_package::NumDiv`: number of divider instances; any value ≥1, not required to be a power of two.
- `DividerWidth`, default `ita_package::DividerWidth`: operand and result width.
- `TagWidth`, default `ita_package::InputAddrWidth`: request tag width.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `flush_i` in 1: abort all outstanding requests.
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake.
- `req_divisor_i` in `DividerWidth`: divisor (op_b).
- `req_tag_i` in `TagWidth`: tag returned with the result.
- `div_valid_o` out `NumDiv` / `div_ready_i` in `NumDiv`: divider input handshakes.
- `div_op_b_o` out `DividerWidth`: shared divisor bus to all dividers.
- `div_flush_o` out 1: flush to all dividers.
- `div_valid_i` in `NumDiv` / `div_ready_o` out `NumDiv`: divider output handshakes.
- `div_res_i` in `NumDiv`×`DividerWidth`: divider results.
- `rsp_valid_o` out 1 / `rsp_ready_i` in 1: response handshake.
- `rsp_res_o` out `DividerWidth`, `rsp_tag_o` out `TagWidth`: response payload.
- `outstanding_o` out `$clog2(NumDiv+1)`: number of in-flight requests.
- `idle_o` out 1: high when `outstanding_o == 0`.

## Operation
- **State:**
  - `occ[NumDiv]`: slot-busy bits.
  - `tag_q[NumDiv]`: stored tags.
  - `disp_ptr`, `ret_ptr` in 0..NumDiv-1.
  - Outstanding counter.
- **Dispatch:**
  - `div_valid_o[disp_ptr] = req_valid_i && !occ[disp_ptr]`; all other `div_valid_o` bits are 0.
  - `req_ready_o = !occ[disp_ptr] && div_ready_i[disp_ptr]`.
  - `div_op_b_o = req_divisor_i`.
- **Accept** (`req_valid_i && req_ready_o`):
  - set `occ[disp_ptr]`;
  - load `tag_q[disp_ptr] = req_tag_i`;
  - advance `disp_ptr` (wraps NumDiv-1→0).
- **Retire:**
  - `rsp_valid_o = occ[ret_ptr] && div_valid_i[ret_ptr]`.
  - `rsp_res_o = div_res_i[ret_ptr]`; `rsp_tag_o = tag_q[ret_ptr]`.
  - `div_ready_o[ret_ptr] = occ[ret_ptr] && rsp_ready_i`; all other bits are 0.
  - On `rsp_valid_o && rsp_ready_i`: clear `occ[ret_ptr]` and advance `ret_ptr` with wrap.
- **Ordering:** a divider that finishes before the slot at `ret_ptr` holds its result (its `div_ready_o` stays low). Responses therefore always follow request order.
- **Counter:** +1 on accept, −1 on retire, unchanged when both happen in the same cycle.
  - Accept and retire never hit the same slot in one cycle, because accept requires `!occ`. With `NumDiv=1`, a slot freed this cycle is reusable next cycle.
- **Full/empty:**
  - Full (`outstanding == NumDiv`): all slots are occupied, so `req_ready_o=0`.
  - Empty: `rsp_valid_o=0` regardless of any stray `div_valid_i`.
- **Flush:**
  - `flush_i` drives `div_flush_o` in the same cycle.
  - Next edge: `occ` cleared, both pointers to 0, counter to 0.
  - While `flush_i` is high, `req_ready_o=0` and `rsp_valid_o=0`.

## Timing
- The scheduler adds no latency. Dispatch and retire are combinational pass-through, so request-to-response latency equals the divider latency.
- **Sustained throughput:** one request per cycle while free slots exist. Steady state is `NumDiv` results per divider latency.
- **Reset:** `rst_i` high at an edge clears all state identically to flush, including mid-operation. Dividers must be reset by the same reset.
- **Output values during reset and after:**
  - `req_ready_o`, `rsp_valid_o`, `div_valid_o`, `div_ready_o` = 0;
  - `outstanding_o` = 0, `idle_o` = 1;
  - `rsp_tag_o` = 0, because `tag_q` resets to 0;
  - `div_flush_o` = `flush_i`.
- `rsp_*` are stable while `rsp_valid_o && !rsp_ready_i`, because the divider holds its result.

## Configuration
- `ITA_DIV_SCHED_ZERO_GUARD_EN` defined:
  - A request with `req_divisor_i == 0` sends `div_op_b_o = 1` and sets a per-slot `zero_q` bit.
  - On retire of that slot, `rsp_res_o` is forced to all-ones.
- `ITA_DIV_SCHED_ZERO_GUARD_EN` undefined:
  - Zero divisors pass through unchanged, and the result is whatever the divider defines for division by zero.
  - No `zero_q` storage is built.

## Structure
- The package `ita_package` holds:
  - `div_tag_t` (`TagWidth`);
  - `div_slot_idx_t` (`$clog2(NumDiv)`, minimum 1 bit);
  - `div_cnt_t`;
  - the existing `NumDiv` and `DividerWidth`.
- No sub-module; the slot array is inline.
- `ita_softmax_top` instantiates this block between `ita_softmax` and the `ita_serdiv` generate loop.

## Test plan
- **Single request:** NumDiv=4, divider model res=65536/b with 5-cycle latency. Request b=4, tag=7 → one response, res=16384, tag=7, 5 cycles after accept; `outstanding_o` 0→1→0.
- **Fill and stall:** issue 5 back-to-back requests.
  - The first 4 are accepted in consecutive cycles, going to dividers 0,1,2,3.
  - The 5th stalls with `req_ready_o=0` until the first response retires, then goes to divider 0.
- **Ordering:** the divider model returns slot 1 three cycles earlier than slot 0, with tags 3 and 9 in that order. Responses must come out tag 3 then tag 9, with slot 1 held (`div_ready_o[1]=0`) until slot 0 retires.
- **Backpressure:** hold `rsp_ready_i=0` for 10 cycles. `rsp_res_o`/`rsp_tag_o` stay constant, nothing is lost, and all 4 results drain in order once ready rises.
- **Flush/reset mid-operation:** with 3 requests outstanding, pulse `flush_i` (separately, `rst_i`).
  - Next cycle: `outstanding_o=0`, `idle_o=1`, no further `rsp_valid_o`.
  - A new request b=2, tag=1 is dispatched to divider 0 and returns res=32768.
- **Zero guard:** request b=0, tag=5.
  - With `ITA_DIV_SCHED_ZERO_GUARD_EN`: `div_op_b_o=1` and the response is res=all-ones, tag=5.
  - Without the macro: `div_op_b_o=0` and the response equals the model's divide-by-zero output.
